// File: rtl/turn_seq_pkg.sv
// Shared types for the turn-signal sequencer: state codes, lamp patterns,
// request decode and sequence-step helpers.
package turn_seq_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE = 4'd0;
  localparam state_t ST_L1   = 4'd1;
  localparam state_t ST_L2   = 4'd2;
  localparam state_t ST_L3   = 4'd3;
  localparam state_t ST_LOFF = 4'd4;
  localparam state_t ST_R1   = 4'd5;
  localparam state_t ST_R2   = 4'd6;
  localparam state_t ST_R3   = 4'd7;
  localparam state_t ST_ROFF = 4'd8;
  localparam state_t ST_HON  = 4'd9;
  localparam state_t ST_HOFF = 4'd10;

  typedef logic [2:0] lamp_t;

  localparam lamp_t LAMP_OFF = 3'b000;
  localparam lamp_t LAMP_1   = 3'b001;
  localparam lamp_t LAMP_2   = 3'b011;
  localparam lamp_t LAMP_3   = 3'b111;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_LEFT,
    REQ_RIGHT,
    REQ_HAZ
  } req_e;

  // Both turn stalks at once counts as hazard.
  function automatic req_e decode_req(
    input logic l,
    input logic r,
    input logic h
  );
    req_e q;
    q = REQ_NONE;
    unique case (1'b1)
      h | (l & r):    q = REQ_HAZ;
      l & ~r & ~h:    q = REQ_LEFT;
      r & ~l & ~h:    q = REQ_RIGHT;
      default:        q = REQ_NONE;
    endcase
    return q;
  endfunction

  function automatic logic is_left(input state_t s);
    return (s == ST_L1) || (s == ST_L2) ||
           (s == ST_L3) || (s == ST_LOFF);
  endfunction

  function automatic logic is_right(input state_t s);
    return (s == ST_R1) || (s == ST_R2) ||
           (s == ST_R3) || (s == ST_ROFF);
  endfunction

  function automatic logic is_haz(input state_t s);
    return (s == ST_HON) || (s == ST_HOFF);
  endfunction

  function automatic state_t step(input state_t s);
    state_t n;
    case (s)
      ST_L1:   n = ST_L2;
      ST_L2:   n = ST_L3;
      ST_L3:   n = ST_LOFF;
      ST_LOFF: n = ST_L1;
      ST_R1:   n = ST_R2;
      ST_R2:   n = ST_R3;
      ST_R3:   n = ST_ROFF;
      ST_ROFF: n = ST_R1;
      ST_HON:  n = ST_HOFF;
      ST_HOFF: n = ST_HON;
      default: n = ST_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/turn_signal_seq_if.sv
// Request/lamp bundle of the turn-signal sequencer.
// master drives left/right/hazard requests; slave drives lamps + active.
interface turn_signal_seq_if;

  logic       left_req;
  logic       right_req;
  logic       hazard_req;
  logic [2:0] l_signal;
  logic [2:0] r_signal;
  logic       active;

  modport master (
    output left_req,
    output right_req,
    output hazard_req,
    input  l_signal,
    input  r_signal,
    input  active
  );

  modport slave (
    input  left_req,
    input  right_req,
    input  hazard_req,
    output l_signal,
    output r_signal,
    output active
  );

endinterface

// File: rtl/turn_signal_seq_prescaler.sv
// tick_prescaler: counts 0..DIV-1 while run is high, pulses tick on the
// last count. Ports: clock, reset_n, run, tick.
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic run,
  output logic tick
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  assign tick = run && (count == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!run || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/turn_signal_seq.sv
// Turn-signal sequencer: left/right/hazard requests -> 3-lamp sweeps.
// Ports: clock, reset_n, bus (slave). Macro: TURN_SEQ_SYNC_EN.
module turn_signal_seq
  import turn_seq_pkg::*;
#(
  parameter int TICK_DIV = 12_500_000
) (
  input logic              clock,
  input logic              reset_n,
  turn_signal_seq_if.slave bus
);

  logic [2:0] req_bits;

`ifdef TURN_SEQ_SYNC_EN
  logic [2:0] sync1;
  logic [2:0] sync2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {bus.hazard_req, bus.right_req, bus.left_req};
      sync2 <= sync1;
    end
  end

  assign req_bits = sync2;
`else
  assign req_bits = {bus.hazard_req, bus.right_req, bus.left_req};
`endif

  req_e   req;
  state_t state;
  state_t state_nxt;
  lamp_t  l_nxt;
  lamp_t  r_nxt;
  logic   act_nxt;
  lamp_t  l_q;
  lamp_t  r_q;
  logic   act_q;
  logic   tick;

  assign req = decode_req(req_bits[0], req_bits[1], req_bits[2]);

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_presc (
    .clock   (clock),
    .reset_n (reset_n),
    .run     (state != ST_IDLE),
    .tick    (tick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      l_q   <= LAMP_OFF;
      r_q   <= LAMP_OFF;
      act_q <= 1'b0;
    end else begin
      state <= state_nxt;
      l_q   <= l_nxt;
      r_q   <= r_nxt;
      act_q <= act_nxt;
    end
  end

  // IDLE reacts immediately; lit states only move on tick.
  always_comb begin
    state_nxt = state;
    if (state == ST_IDLE) begin
      unique case (req)
        REQ_HAZ:   state_nxt = ST_HON;
        REQ_LEFT:  state_nxt = ST_L1;
        REQ_RIGHT: state_nxt = ST_R1;
        REQ_NONE:  state_nxt = ST_IDLE;
      endcase
    end else if (tick) begin
      unique case (req)
        REQ_NONE:
          state_nxt = ST_IDLE;
        REQ_HAZ:
          state_nxt = is_haz(state) ? step(state) : ST_HON;
        REQ_LEFT:
          state_nxt = is_left(state) ? step(state) : ST_L1;
        REQ_RIGHT:
          state_nxt = is_right(state) ? step(state) : ST_R1;
      endcase
    end
  end

  // Decoded from next state so lamps move on the state edge.
  always_comb begin
    l_nxt   = LAMP_OFF;
    r_nxt   = LAMP_OFF;
    act_nxt = (state_nxt != ST_IDLE);
    case (state_nxt)
      ST_L1:   l_nxt = LAMP_1;
      ST_L2:   l_nxt = LAMP_2;
      ST_L3:   l_nxt = LAMP_3;
      ST_R1:   r_nxt = LAMP_1;
      ST_R2:   r_nxt = LAMP_2;
      ST_R3:   r_nxt = LAMP_3;
      ST_HON: begin
        l_nxt = LAMP_3;
        r_nxt = LAMP_3;
      end
      default: begin
        l_nxt = LAMP_OFF;
        r_nxt = LAMP_OFF;
      end
    endcase
  end

  assign bus.l_signal = l_q;
  assign bus.r_signal = r_q;
  assign bus.active   = act_q;

endmodule

// File: tb/tb_turn_signal_seq.sv
// Bench for turn_signal_seq at TICK_DIV=4: vector table plus reset and
// request-pulse sequences, checked through an expected-value queue.
module tb_turn_signal_seq;

  localparam int DIV = 4;
`ifdef TURN_SEQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  turn_signal_seq_if bus ();

  turn_signal_seq #(
    .TICK_DIV (DIV)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic       l;
    logic       r;
    logic       h;
    int         n;
    logic [2:0] el;
    logic [2:0] er;
    logic       ea;
  } vec_t;

  typedef struct packed {
    logic [2:0] l;
    logic [2:0] r;
    logic       a;
  } obs_t;

  vec_t tbl[$];
  obs_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(
    input logic l, input logic r, input logic h, input int n,
    input logic [2:0] el, input logic [2:0] er, input logic ea
  );
    vec_t v;
    v.l = l; v.r = r; v.h = h; v.n = n;
    v.el = el; v.er = er; v.ea = ea;
    return v;
  endfunction

  task automatic check(input string name);
    obs_t e;
    obs_t a;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected entry queued", name);
    end else begin
      e = sb.pop_front();
      a = {bus.l_signal, bus.r_signal, bus.active};
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got l=%b r=%b act=%b, want l=%b r=%b act=%b",
                 name, a.l, a.r, a.a, e.l, e.r, e.a);
      end
    end
  endtask

  // Drive on negedge, hold n rising edges, sample on the next negedge.
  task automatic apply(
    input logic l, input logic r, input logic h, input int n,
    input logic [2:0] el, input logic [2:0] er, input logic ea,
    input string name
  );
    bus.left_req   = l;
    bus.right_req  = r;
    bus.hazard_req = h;
    sb.push_back({el, er, ea});
    repeat (n) @(posedge clk);
    @(negedge clk);
    check(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    bus.left_req   = 1'b0;
    bus.right_req  = 1'b0;
    bus.hazard_req = 1'b0;
    repeat (2) @(negedge clk);
    sb.push_back({3'b000, 3'b000, 1'b0});
    check("reset_state");
    rst_n = 1'b1;

`ifndef TURN_SEQ_SYNC_EN
    // left sweep
    tbl.push_back(mk(0,0,0,2, 3'b000,3'b000,0));
    tbl.push_back(mk(1,0,0,1, 3'b001,3'b000,1));
    tbl.push_back(mk(1,0,0,3, 3'b001,3'b000,1));
    tbl.push_back(mk(1,0,0,1, 3'b011,3'b000,1));
    tbl.push_back(mk(1,0,0,4, 3'b111,3'b000,1));
    tbl.push_back(mk(1,0,0,4, 3'b000,3'b000,1));
    tbl.push_back(mk(1,0,0,4, 3'b001,3'b000,1));
    tbl.push_back(mk(1,0,0,4, 3'b011,3'b000,1));
    // drop during L2
    tbl.push_back(mk(0,0,0,3, 3'b011,3'b000,1));
    tbl.push_back(mk(0,0,0,1, 3'b000,3'b000,0));
    // hazard during R2
    tbl.push_back(mk(0,1,0,1, 3'b000,3'b001,1));
    tbl.push_back(mk(0,1,0,4, 3'b000,3'b011,1));
    tbl.push_back(mk(0,0,1,2, 3'b000,3'b011,1));
    tbl.push_back(mk(0,0,1,2, 3'b111,3'b111,1));
    tbl.push_back(mk(0,0,1,4, 3'b000,3'b000,1));
    tbl.push_back(mk(0,0,1,4, 3'b111,3'b111,1));
    tbl.push_back(mk(0,1,0,4, 3'b000,3'b001,1));
    tbl.push_back(mk(0,0,0,4, 3'b000,3'b000,0));
    // both stalks from IDLE, then drop right
    tbl.push_back(mk(1,1,0,1, 3'b111,3'b111,1));
    tbl.push_back(mk(1,0,0,3, 3'b111,3'b111,1));
    tbl.push_back(mk(1,0,0,1, 3'b001,3'b000,1));
    // switch side mid-sequence
    tbl.push_back(mk(0,1,0,4, 3'b000,3'b001,1));
    // drop and reassert within one step
    tbl.push_back(mk(0,0,0,2, 3'b000,3'b001,1));
    tbl.push_back(mk(0,1,0,2, 3'b000,3'b011,1));
    tbl.push_back(mk(0,0,0,4, 3'b000,3'b000,0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].l, tbl[i].r, tbl[i].h, tbl[i].n,
            tbl[i].el, tbl[i].er, tbl[i].ea,
            $sformatf("vec%0d", i));
    end

    // one-cycle right pulse from IDLE
    apply(0,1,0,1, 3'b000,3'b001,1, "pulse_lit");
    apply(0,0,0,4, 3'b000,3'b000,0, "pulse_idle");
`else
    // one-cycle right pulse through the synchronizer
    apply(0,1,0,1, 3'b000,3'b000,0, "sync_pulse_c1");
    apply(0,0,0,1, 3'b000,3'b000,0, "sync_pulse_c2");
    apply(0,0,0,1, 3'b000,3'b001,1, "sync_pulse_c3");
    apply(0,0,0,4, 3'b000,3'b000,0, "sync_pulse_idle");
`endif

    // async reset in L3
    apply(1,0,0,LAT, 3'b001,3'b000,1, "rst_l1");
    apply(1,0,0,8,   3'b111,3'b000,1, "rst_l3");
    apply(1,0,0,2,   3'b111,3'b000,1, "rst_l3_mid");
    rst_n = 1'b0;
    #2;
    sb.push_back({3'b000, 3'b000, 1'b0});
    check("rst_async");
    bus.left_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    apply(0,0,0,2,   3'b000,3'b000,0, "rst_idle");
    apply(1,0,0,LAT, 3'b001,3'b000,1, "rst_recover");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
